// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the decoder/pipeline control interface: MemRead kinds,
// EX operand forward selects and the opcodes the decoder recognises.
package ctrl_pipe_pkg;

  localparam logic [1:0] MR_NONE = 2'd0;
  localparam logic [1:0] MR_LW   = 2'd1;
  localparam logic [1:0] MR_LH   = 2'd2;
  localparam logic [1:0] MR_LHU  = 2'd3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational hazard detection: stall, flush, branch_taken and EX forward selects.
// CTRL_PIPE_FWD_EN enables forwarding so only load-use dependencies stall.
module hazard_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MR_W   = 2
) (
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_alusrc_i,
  input  logic              id_memwrite_i,
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic              ex_regwrite_i,
  input  logic [MR_W-1:0]   ex_memread_i,
  input  logic              ex_branch_i,
  input  logic              ex_zero_i,
  input  logic [REG_AW-1:0] mem_dst_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] wb_dst_i,
  input  logic              wb_regwrite_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic              branch_taken_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic hit(logic [REG_AW-1:0] src, logic [REG_AW-1:0] dst, logic we);
    return we && (src != '0) && (src == dst);
  endfunction

  logic rt_used;
  logic dep_ex;

  assign rt_used = !id_alusrc_i || id_memwrite_i;
  assign dep_ex  = hit(id_rs_i, ex_dst_i, ex_regwrite_i) ||
                   (rt_used && hit(id_rt_i, ex_dst_i, ex_regwrite_i));

  assign branch_taken_o = ex_branch_i & ex_zero_i;
  assign flush_o        = branch_taken_o;

`ifdef CTRL_PIPE_FWD_EN
  logic load_use;

  assign load_use = (ex_memread_i != '0) && dep_ex;
  assign stall_o  = load_use && !branch_taken_o;

  always_comb begin
    fwd_a_o = FWD_REG;
    fwd_b_o = FWD_REG;
    if (hit(ex_rs_i, mem_dst_i, mem_regwrite_i))     fwd_a_o = FWD_MEM;
    else if (hit(ex_rs_i, wb_dst_i, wb_regwrite_i))  fwd_a_o = FWD_WB;
    if (hit(ex_rt_i, mem_dst_i, mem_regwrite_i))     fwd_b_o = FWD_MEM;
    else if (hit(ex_rt_i, wb_dst_i, wb_regwrite_i))  fwd_b_o = FWD_WB;
  end
`else
  logic dep_mem;
  logic unused_fwd;

  assign dep_mem = hit(id_rs_i, mem_dst_i, mem_regwrite_i) ||
                   (rt_used && hit(id_rt_i, mem_dst_i, mem_regwrite_i));
  // Without forwarding the dependent instruction waits until the producer reaches WB.
  assign stall_o    = (dep_ex || dep_mem) && !branch_taken_o;
  assign fwd_a_o    = FWD_REG;
  assign fwd_b_o    = FWD_REG;
  assign unused_fwd = ^{ex_rs_i, ex_rt_i, ex_memread_i, wb_dst_i, wb_regwrite_i};
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with destination selection and
// bubble insertion. CTRL_PIPE_FWD_EN selects the forwarding hazard policy.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MR_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_regdst,
  input  logic              id_branch,
  input  logic              id_memtoreg,
  input  logic              id_memwrite,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic [MR_W-1:0]   id_memread,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              ex_regwrite,
  output logic [MR_W-1:0]   ex_memread,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              mem_regwrite,
  output logic [MR_W-1:0]   mem_memread,
  output logic              mem_memwrite,
  output logic              mem_memtoreg,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] ex_dst,
  output logic [REG_AW-1:0] mem_dst,
  output logic [REG_AW-1:0] wb_dst,
  output logic              stall,
  output logic              flush,
  output logic              branch_taken,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  typedef struct packed {
    logic              regwrite;
    logic [MR_W-1:0]   memread;
    logic              memwrite;
    logic              alusrc;
    logic              branch;
    logic              memtoreg;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } ex_stage_t;

  typedef struct packed {
    logic              regwrite;
    logic [MR_W-1:0]   memread;
    logic              memwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] dst;
  } mem_stage_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] dst;
  } wb_stage_t;

  ex_stage_t  ex_d,  ex_q;
  mem_stage_t mem_d, mem_q;
  wb_stage_t  wb_d,  wb_q;

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !branch_taken) begin
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.memwrite = id_memwrite;
      ex_d.alusrc   = id_alusrc;
      ex_d.branch   = id_branch;
      ex_d.memtoreg = id_memtoreg;
      // Non-writing instructions carry dst 0 so don't-care regdst decodes stay contained.
      ex_d.dst      = id_regwrite ? (id_regdst ? id_rd : id_rt) : '0;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
    end

    mem_d.regwrite = ex_q.regwrite;
    mem_d.memread  = ex_q.memread;
    mem_d.memwrite = ex_q.memwrite;
    mem_d.memtoreg = ex_q.memtoreg;
    mem_d.dst      = ex_q.dst;

    wb_d.regwrite  = mem_q.regwrite;
    wb_d.memtoreg  = mem_q.memtoreg;
    wb_d.dst       = mem_q.dst;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_regwrite  = ex_q.regwrite;
  assign ex_memread   = ex_q.memread;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_branch    = ex_q.branch;
  assign ex_dst       = ex_q.dst;
  assign mem_regwrite = mem_q.regwrite;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_memtoreg = mem_q.memtoreg;
  assign mem_dst      = mem_q.dst;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign wb_dst       = wb_q.dst;

  hazard_unit #(
    .REG_AW (REG_AW),
    .MR_W   (MR_W)
  ) u_hazard (
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_alusrc_i    (id_alusrc),
    .id_memwrite_i  (id_memwrite),
    .ex_rs_i        (ex_q.rs),
    .ex_rt_i        (ex_q.rt),
    .ex_dst_i       (ex_q.dst),
    .ex_regwrite_i  (ex_q.regwrite),
    .ex_memread_i   (ex_q.memread),
    .ex_branch_i    (ex_q.branch),
    .ex_zero_i      (ex_zero),
    .mem_dst_i      (mem_q.dst),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_dst_i       (wb_q.dst),
    .wb_regwrite_i  (wb_q.regwrite),
    .stall_o        (stall),
    .flush_o        (flush),
    .branch_taken_o (branch_taken),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed program snippets plus random instruction streams,
// compared against an in-flight instruction model. Honours CTRL_PIPE_FWD_EN.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned MW = 2;
`ifdef CTRL_PIPE_FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid = 1'b0, id_regdst = 1'b0, id_branch = 1'b0, id_memtoreg = 1'b0;
  logic          id_memwrite = 1'b0, id_alusrc = 1'b0, id_regwrite = 1'b0;
  logic [MW-1:0] id_memread = '0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          ex_zero = 1'b0;
  logic          ex_regwrite, ex_memwrite, ex_alusrc, ex_branch;
  logic [MW-1:0] ex_memread, mem_memread;
  logic          mem_regwrite, mem_memwrite, mem_memtoreg, wb_regwrite, wb_memtoreg;
  logic [AW-1:0] ex_dst, mem_dst, wb_dst;
  logic          stall, flush, branch_taken;
  logic [1:0]    fwd_a, fwd_b;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_AW(AW), .MR_W(MW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_regdst(id_regdst),
    .id_branch(id_branch), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .ex_dst(ex_dst),
    .mem_dst(mem_dst), .wb_dst(wb_dst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef struct packed {
    logic valid, regdst, branch, memtoreg, memwrite, alusrc, regwrite;
    logic [MW-1:0] memread;
    logic [AW-1:0] rs, rt, rd;
  } instr_t;

  // One in-flight instruction as seen by later stages; pipe[0]=EX, [1]=MEM, [2]=WB.
  typedef struct packed {
    logic regwrite;
    logic [MW-1:0] memread;
    logic memwrite, alusrc, branch, memtoreg;
    logic [AW-1:0] dst, rs, rt;
  } slot_t;

  slot_t pipe [3];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  obs_stall, obs_flush, obs_bt, obs_ex_rw, exp_stall;
  logic [1:0]    obs_fwd_a, obs_fwd_b;
  logic [AW-1:0] obs_ex_dst;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes_reg(slot_t s, logic [AW-1:0] r);
    return s.regwrite && (r != 0) && (r == s.dst);
  endfunction

  function automatic bit depends(instr_t i, slot_t s);
    return writes_reg(s, i.rs) || ((!i.alusrc || i.memwrite) && writes_reg(s, i.rt));
  endfunction

  function automatic logic [1:0] src_sel(logic [AW-1:0] r);
    if (FwdOn && writes_reg(pipe[1], r)) return FWD_MEM;
    if (FwdOn && writes_reg(pipe[2], r)) return FWD_WB;
    return FWD_REG;
  endfunction

  function automatic instr_t mk(logic rsel, logic br, logic m2r, logic mw, logic asrc, logic rw,
                               logic [1:0] mr, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    instr_t i;
    i = '{valid: 1'b1, regdst: rsel, branch: br, memtoreg: m2r, memwrite: mw, alusrc: asrc,
          regwrite: rw, memread: mr, rs: rs, rt: rt, rd: rd};
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.valid    = ($urandom_range(0, 7) != 0);
    i.regdst   = 1'($urandom_range(0, 1));
    i.branch   = ($urandom_range(0, 7) == 0);
    i.memtoreg = 1'($urandom_range(0, 1));
    i.memwrite = ($urandom_range(0, 3) == 0);
    i.alusrc   = 1'($urandom_range(0, 1));
    i.regwrite = ($urandom_range(0, 3) != 0);
    i.memread  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : MR_NONE;
    i.rs       = 5'($urandom_range(0, 3));
    i.rt       = 5'($urandom_range(0, 3));
    i.rd       = 5'($urandom_range(0, 3));
    return i;
  endfunction

  task automatic apply(instr_t i, logic z);
    id_valid = i.valid;       id_regdst = i.regdst;     id_branch = i.branch;
    id_memtoreg = i.memtoreg; id_memwrite = i.memwrite; id_alusrc = i.alusrc;
    id_regwrite = i.regwrite; id_memread = i.memread;
    id_rs = i.rs;             id_rt = i.rt;             id_rd = i.rd;
    ex_zero = z;
  endtask

  task automatic check_outputs(logic stl, logic bt);
    check("stall", stall, stl);
    check("flush", flush, bt);
    check("branch_taken", branch_taken, bt);
    check("fwd_a", fwd_a, src_sel(pipe[0].rs));
    check("fwd_b", fwd_b, src_sel(pipe[0].rt));
    check("ex_regwrite", ex_regwrite, pipe[0].regwrite);
    check("ex_memread", ex_memread, pipe[0].memread);
    check("ex_memwrite", ex_memwrite, pipe[0].memwrite);
    check("ex_alusrc", ex_alusrc, pipe[0].alusrc);
    check("ex_branch", ex_branch, pipe[0].branch);
    check("ex_dst", ex_dst, pipe[0].dst);
    check("mem_regwrite", mem_regwrite, pipe[1].regwrite);
    check("mem_memread", mem_memread, pipe[1].memread);
    check("mem_memwrite", mem_memwrite, pipe[1].memwrite);
    check("mem_memtoreg", mem_memtoreg, pipe[1].memtoreg);
    check("mem_dst", mem_dst, pipe[1].dst);
    check("wb_regwrite", wb_regwrite, pipe[2].regwrite);
    check("wb_memtoreg", wb_memtoreg, pipe[2].memtoreg);
    check("wb_dst", wb_dst, pipe[2].dst);
  endtask

  // One clock: present i in ID, compare everything, then advance the model.
  task automatic step(instr_t i, logic z);
    slot_t nxt;
    logic  bt, stl;
    @(negedge clk);
    apply(i, z);
    #1;
    bt  = pipe[0].branch && z;
    stl = !bt && (FwdOn ? ((pipe[0].memread != 0) && depends(i, pipe[0]))
                        : (depends(i, pipe[0]) || depends(i, pipe[1])));
    check_outputs(stl, bt);
    obs_stall = stall;  obs_flush = flush;  obs_bt = branch_taken;
    obs_fwd_a = fwd_a;  obs_fwd_b = fwd_b;  obs_ex_dst = ex_dst;  obs_ex_rw = ex_regwrite;
    exp_stall = stl;
    nxt = '0;
    if (i.valid && !stl && !bt) begin
      nxt.regwrite = i.regwrite;
      nxt.memread  = i.memread;
      nxt.memwrite = i.memwrite;
      nxt.alusrc   = i.alusrc;
      nxt.branch   = i.branch;
      nxt.memtoreg = i.memtoreg;
      nxt.dst      = !i.regwrite ? '0 : (i.regdst ? i.rd : i.rt);
      nxt.rs       = i.rs;
      nxt.rt       = i.rt;
    end
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nxt;
  endtask

  // Assert reset mid-cycle with i in ID; everything must clear before the next edge.
  task automatic do_reset(instr_t i);
    @(negedge clk);
    apply(i, 1'b0);
    #2 reset = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    check_outputs(1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    repeat (3) step(instr_t'(0), 1'b0);
  endtask

  initial begin
    instr_t lw9, lw10, add10, add9, sub12, beq, addi0, add9z, sw9, addi10, cur;
    int     nst;
    lw9    = mk(0, 0, 1, 0, 1, 1, MR_LW,   16, 9,  0);
    lw10   = mk(0, 0, 1, 0, 1, 1, MR_LW,   16, 10, 0);
    add10  = mk(1, 0, 0, 0, 0, 1, MR_NONE, 9,  11, 10);
    add9   = mk(1, 0, 0, 0, 0, 1, MR_NONE, 10, 11, 9);
    sub12  = mk(1, 0, 0, 0, 0, 1, MR_NONE, 9,  9,  12);
    beq    = mk(0, 1, 0, 0, 0, 0, MR_NONE, 3,  4,  0);
    addi0  = mk(0, 0, 0, 0, 1, 1, MR_NONE, 0,  0,  0);
    add9z  = mk(1, 0, 0, 0, 0, 1, MR_NONE, 0,  0,  9);
    sw9    = mk(0, 0, 0, 1, 1, 0, MR_NONE, 16, 9,  0);
    addi10 = mk(0, 0, 0, 0, 1, 1, MR_NONE, 16, 10, 0);

    do_reset(instr_t'(0));

    // Load-use: lw $9 then add reading $9.
    step(lw9, 1'b0);
    nst = 0;
    for (int g = 0; g < 4; g++) begin
      step(add10, 1'b0);
      if (obs_stall) nst++;
      else break;
    end
    check("lu_stall_cycles", nst, FwdOn ? 1 : 2);
    step(instr_t'(0), 1'b0);
    check("lu_fwd_a", obs_fwd_a, FwdOn ? FWD_WB : FWD_REG);

    // ALU-to-ALU dependency on both operands.
    drain();
    step(add9, 1'b0);
    nst = 0;
    for (int g = 0; g < 4; g++) begin
      step(sub12, 1'b0);
      if (obs_stall) nst++;
      else break;
    end
    check("alu_stall_cycles", nst, FwdOn ? 0 : 2);
    step(instr_t'(0), 1'b0);
    check("alu_fwd_a", obs_fwd_a, FwdOn ? FWD_MEM : FWD_REG);
    check("alu_fwd_b", obs_fwd_b, FwdOn ? FWD_MEM : FWD_REG);

    // Taken branch in EX beats a hazard on the ID instruction.
    drain();
    step(lw9, 1'b0);
    step(beq, 1'b0);
    step(add10, 1'b1);
    check("br_taken", obs_bt, 1);
    check("br_flush", obs_flush, 1);
    check("br_stall", obs_stall, 0);
    step(instr_t'(0), 1'b0);
    check("br_bubble_rw", obs_ex_rw, 0);

    // Writes to $0 never create hazards.
    drain();
    step(addi0, 1'b0);
    step(add9z, 1'b0);
    check("r0_stall", obs_stall, 0);
    check("r0_ex_dst", obs_ex_dst, 0);
    step(instr_t'(0), 1'b0);
    check("r0_fwd_a", obs_fwd_a, FWD_REG);
    check("r0_fwd_b", obs_fwd_b, FWD_REG);

    // rt counts as a source for sw but not for addi.
    drain();
    step(lw9, 1'b0);
    step(sw9, 1'b0);
    check("sw_rt_stall", obs_stall, 1);
    drain();
    step(lw10, 1'b0);
    step(addi10, 1'b0);
    check("addi_rt_stall", obs_stall, 0);

    // Reset while EX holds a load and ID is stalled on it.
    drain();
    step(lw9, 1'b0);
    do_reset(add10);

    // Random streams; a stalled ID instruction is re-presented.
    cur = rand_instr();
    for (int k = 0; k < 600; k++) begin
      if (k % 97 == 60) do_reset(cur);
      step(cur, 1'($urandom_range(0, 1)));
      if (!exp_stall) cur = rand_instr();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
